quadrature_generator: RTL and testbench
=======================================

# quadrature_generator

Emulates the output side of a rotary quadrature encoder. It converts step commands (direction, edge count, edge spacing) into A/B quadrature waveforms plus an index pulse, and tracks position modulo one revolution. It pairs with the rotational encoder input block as its stimulus source and loop-back partner, and it also serves as a stand-alone encoder emulator driven by a control FSM.

## Interface
- CPR, 96: quadrature edges (counts) per revolution; multiple of 4, at least 4.
- STEP_W, 16: width of the step count field.
- DIV_W, 16: width of the edge-spacing field.
- POS_W, $clog2(CPR): position width (derived).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_dir  in  1  1 = CW, count up, A leads B; 0 = CCW, count down, B leads A.
- cmd_steps  in  STEP_W  number of quadrature edges to emit; 0 is legal.
- cmd_half_period  in  DIV_W  clk cycles between successive edges; 0 is treated as 1.
- stop  in  1  synchronous abort.
- enc_a  out  1  quadrature channel A (registered).
- enc_b  out  1  quadrature channel B (registered).
- enc_z  out  1  index; high exactly while position == 0 (registered).
- position  out  POS_W  current count, range 0..CPR-1.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal command completion.

## Operation
- FSM states:
  - IDLE: cmd_ready = !stop.
  - RUN: cmd_ready = 0, busy = 1.
- Command handshake in IDLE: cmd_valid & cmd_ready latches dir, steps and max(half_period, 1).
  - steps == 0: stay in IDLE, pulse done next cycle, emit no edges.
  - steps > 0: go to RUN and load the interval timer with the latched half period.
- In RUN, the timer counts down each cycle. On expiry:
  - Step position by one edge: +1 when dir=1, −1 when dir=0.
  - Decrement the remaining-step counter and reload the timer.
  - If the remaining count reaches 0, return to IDLE and pulse done in the same cycle as the final edge.
- Position wraps: CPR-1 +1 → 0, and 0 −1 → CPR-1.
- A/B derive from position[1:0]: 0→(A,B)=00, 1→10, 2→11, 3→01. Because CPR is a multiple of 4, wrap is phase-continuous and A/B change one channel per edge (Gray).
- enc_z = (next position == 0), registered with A/B so all three outputs change on the same clk edge.
- stop in RUN: return to IDLE on the next edge with no further position change. Position and A/B are retained and done is not pulsed.
- stop in IDLE blocks acceptance (cmd_ready low).
- Command fields are ignored outside the accept cycle.

## Timing
- Reset (async, while rst high): state=IDLE, position=0, enc_a=0, enc_b=0, enc_z=1, busy=0, done=0, timers cleared. cmd_ready = !stop.
- Reset mid-RUN aborts immediately. Outputs go to reset values without waiting for clk.
- The command is accepted at edge T. Edge k (1..N) appears at edge T + k·hp. done=1 and cmd_ready=1 during the cycle following edge T + N·hp.
- Back-to-back: a second command held valid is accepted at the edge after the completion cycle. Its first edge follows hp cycles after that acceptance.
- Edge rate = f_clk/hp. Per-channel frequency = f_clk/(4·hp).
- Zero-step command: done at T+1, cmd_ready stays high, no output change.
- stop and timer expiry in the same cycle: stop wins, no edge.

## Test plan
- Reset: rst pulsed mid-RUN at position 5 → A=0, B=0, Z=1, position=0, busy=0 immediately. No edges after rst release until a new command.
- CW: dir=1, steps=8, hp=3 from position 0 → edges at T+3,6,…,24. A,B go 10,11,01,00,10,11,01,00. Position ends at 8, Z falls at T+3, done is a single pulse.
- CCW wrap: dir=0, steps=2, hp=0 from position 0 → position 95 (A,B=01) at T+1, then 94 (11) at T+2. Z goes 1→0 at T+1.
- Full revolution: dir=1, steps=96, hp=1 → Z high again only at T+96 with position 0 and A,B=00. Exactly one Z assertion during the run.
- Back-to-back and zero-step: command (1,4,2) followed immediately by (0,0,x) then (0,4,2), cmd_valid held → the second command's done occurs 1 cycle after its accept. Position returns to 0, and edge spacing stays 2.
- Abort: dir=1, steps=10, hp=4; stop asserted for one cycle after the 3rd edge → position=3, A,B=01, busy=0, no done, cmd_ready high after stop drops.

Source files
------------

// File: rtl/quadrature_generator.sv
// Quadrature encoder emulator: turns step commands into A/B/Z waveforms and tracks position mod CPR.
// Latency: command accepted on edge T, edge k appears on edge T + k*hp; done pulses in the cycle after the final edge.
// Backpressure: cmd_ready only in IDLE with stop low; a held command waits until the running one completes.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready  command handshake; cmd_dir (1=CW/up), cmd_steps (edges), cmd_half_period (cycles/edge, 0->1)
//   stop             synchronous abort (RUN) / acceptance block (IDLE)
//   enc_a/b/z        registered quadrature outputs and index (high while position == 0)
//   position         current count 0..CPR-1
//   busy, done       RUN indicator, one-cycle completion pulse
module quadrature_generator #(
  parameter int CPR    = 96,
  parameter int STEP_W = 16,
  parameter int DIV_W  = 16,
  parameter int POS_W  = $clog2(CPR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_half_period,
  input  logic              stop,
  output logic              enc_a,
  output logic              enc_b,
  output logic              enc_z,
  output logic [POS_W-1:0]  position,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(CPR - 1);

  state_t            state;
  logic              dir;
  logic [STEP_W-1:0] remaining;
  logic [DIV_W-1:0]  hp;
  logic [DIV_W-1:0]  timer;

  logic [DIV_W-1:0]  hp_eff;
  logic [POS_W-1:0]  pos_inc;
  logic [POS_W-1:0]  pos_dec;
  logic [POS_W-1:0]  pos_step;

  // A zero spacing would never expire; treat it as one cycle per edge.
  assign hp_eff = (cmd_half_period == '0) ? DIV_W'(1) : cmd_half_period;

  // Explicit wrap at CPR, which need not be a power of two.
  assign pos_inc  = (position == POS_MAX) ? '0 : position + POS_W'(1);
  assign pos_dec  = (position == '0) ? POS_MAX : position - POS_W'(1);
  assign pos_step = dir ? pos_inc : pos_dec;

  assign cmd_ready = (state == IDLE) && !stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= 1'b0;
      remaining <= '0;
      hp        <= '0;
      timer     <= '0;
      position  <= '0;
      enc_a     <= 1'b0;
      enc_b     <= 1'b0;
      enc_z     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && !stop) begin
            dir       <= cmd_dir;
            hp        <= hp_eff;
            timer     <= hp_eff;
            remaining <= cmd_steps;
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          // stop takes priority over a coinciding timer expiry: no edge is emitted.
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer <= DIV_W'(1)) begin
            position  <= pos_step;
            // Gray sequence 00,10,11,01 over position[1:0]; Z registered alongside.
            enc_a     <= pos_step[1] ^ pos_step[0];
            enc_b     <= pos_step[1];
            enc_z     <= (pos_step == '0);
            remaining <= remaining - STEP_W'(1);
            timer     <= hp;
            if (remaining == STEP_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            timer <= timer - DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_generator.sv
module tb_quadrature_generator;

  localparam int CPR   = 96;
  localparam int POS_W = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_dir = 1'b0;
  logic [15:0]       cmd_steps = '0;
  logic [15:0]       cmd_half_period = '0;
  logic              stop = 1'b0;
  logic              enc_a, enc_b, enc_z;
  logic [POS_W-1:0]  position;
  logic              busy, done;

  quadrature_generator #(.CPR(CPR), .STEP_W(16), .DIV_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_half_period(cmd_half_period),
    .stop(stop),
    .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .position(position), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected state from a given edge onward; done holds only for that edge's cycle.
  typedef struct {
    int cyc;
    int pos;
    bit busy;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur = '{0, 0, 1'b0, 1'b0};
  int   cur_cyc = -1;
  int   model_pos = 0;
  int   checks = 0;
  int   passes = 0;

  function automatic logic [1:0] ab_of(int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  // Compare every output once per cycle, on the falling edge.
  task automatic run(int n);
    logic [31:0] obs, expv;
    logic [1:0]  ab;
    bit          done_e, ready_e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        cur     = exp_q.pop_front();
        cur_cyc = cyc;
      end
      ab      = ab_of(cur.pos);
      done_e  = cur.done && (cur_cyc == cyc);
      ready_e = !cur.busy && !stop;
      obs  = {19'd0, position, enc_a, enc_b, enc_z, busy, done, cmd_ready};
      expv = {19'd0, POS_W'(cur.pos), ab, (cur.pos == 0), cur.busy, done_e, ready_e};
      chk($sformatf("outputs@cyc%0d {pos,a,b,z,busy,done,ready}", cyc), obs, expv);
    end
  endtask

  // Drive a command (call right after a falling-edge compare) and queue its expected edges.
  task automatic issue(bit dir, int steps, int hp, bit hold);
    int t, h, p;
    cmd_dir         = dir;
    cmd_steps       = 16'(steps);
    cmd_half_period = 16'(hp);
    cmd_valid       = 1'b1;
    t = cyc + 1;
    h = (hp == 0) ? 1 : hp;
    p = model_pos;
    if (steps == 0) begin
      exp_q.push_back('{t, p, 1'b0, 1'b1});
    end else begin
      exp_q.push_back('{t, p, 1'b1, 1'b0});
      for (int k = 1; k <= steps; k++) begin
        p = dir ? (p + 1) % CPR : (p + CPR - 1) % CPR;
        exp_q.push_back('{t + k * h, p, (k < steps), (k == steps)});
      end
    end
    model_pos = p;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Raise stop for one cycle: the run freezes at its current expected position.
  task automatic abort_now();
    stop = 1'b1;
    exp_q.delete();
    model_pos = cur.pos;
    exp_q.push_back('{cyc + 1, cur.pos, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    stop = 1'b0;
  endtask

  initial begin
    // Reset state held across a few cycles.
    run(3);
    rst = 1'b0;
    run(2);

    // CW 8 edges, hp=3: A,B 10,11,01,00,... position ends at 8.
    issue(1'b1, 8, 3, 1'b0);
    run(25);
    chk("cw_sb_empty", 32'(exp_q.size()), 32'd0);
    run(2);

    // Reset mid-run at position 5: outputs clear without a clock edge.
    issue(1'b0, 10, 1, 1'b0);
    run(4);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pos", 32'(position), 32'd0);
    chk("rst_async_ab", 32'({enc_a, enc_b}), 32'd0);
    chk("rst_async_z", 32'(enc_z), 32'd1);
    chk("rst_async_busy_done", 32'({busy, done}), 32'd0);
    exp_q.delete();
    model_pos = 0;
    cur = '{0, 0, 1'b0, 1'b0};
    run(2);
    rst = 1'b0;
    run(5);

    // CCW wrap, hp=0 treated as 1: 95 then 94.
    issue(1'b0, 2, 0, 1'b0);
    run(3);
    chk("ccw_sb_empty", 32'(exp_q.size()), 32'd0);
    issue(1'b1, 2, 1, 1'b0);
    run(3);

    // Full revolution: Z only at the final edge.
    issue(1'b1, 96, 1, 1'b0);
    run(97);
    chk("rev_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rev_pos", 32'(position), 32'd0);
    run(2);

    // Back-to-back with cmd_valid held: (1,4,2), (0,0,x), (0,4,2).
    issue(1'b1, 4, 2, 1'b1);
    run(9);
    issue(1'b0, 0, int'($urandom_range(0, 65535)), 1'b1);
    run(1);
    issue(1'b0, 4, 2, 1'b0);
    run(9);
    chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
    run(2);

    // Abort after the 3rd edge: position 3, A,B=01, no done.
    issue(1'b1, 10, 4, 1'b0);
    run(13);
    abort_now();
    run(6);
    chk("abort_pos", 32'(position), 32'd3);

    // stop in IDLE blocks acceptance of a valid command.
    stop      = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 16'd5;
    cmd_half_period = 16'd1;
    cmd_valid = 1'b1;
    run(3);
    cmd_valid = 1'b0;
    stop      = 1'b0;
    run(3);

    // stop coinciding with timer expiry: no edge.
    issue(1'b1, 2, 2, 1'b0);
    run(2);
    abort_now();
    run(4);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
